deserializer_from_scope: RTL and testbench

//  Receive end of the single-wire timestamp link: recovers 32-bit frames sent LSB-first at 1 bit/clk.

---
 rtl/deser_pkg.sv | 17 +
 rtl/bit_sync2.sv | 21 ++
 rtl/deserializer_from_scope.sv | 136 +++++++++++++
 tb/tb_deserializer_from_scope.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and constants for the single-wire timestamp link receiver.
package deser_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED,
    ST_IDLE,
    ST_DATA,
    ST_SYNC_LO,
    ST_SYNC_HI
  } state_e;

  localparam logic SYNC_LO_BIT = 1'b0;
  localparam logic SYNC_HI_BIT = 1'b1;
  localparam int   FRAME_BITS  = 40;
  localparam int   ERR_CNT_W   = 8;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, both flops reset to 0.
module bit_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/deserializer_from_scope.sv
// Single-wire timestamp link receiver: recovers LSB-first frames framed by 0/1 sync pairs.
// Define DESER_INSYNC_EN to put a 2-FF synchroniser in front of the FSM (+2 cycles latency).
module deserializer_from_scope
  import deser_pkg::*;
#(
  parameter int NBYTES   = 4,
  parameter int IDLE_MIN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_in,
  output logic [8*NBYTES-1:0]   frame,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int FW     = 8 * NBYTES;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int RUN_W  = $clog2(IDLE_MIN + 1);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic line;

`ifdef DESER_INSYNC_EN
  bit_sync2 u_insync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (data_in),
    .q     (line)
  );
`else
  assign line = data_in;
`endif

  state_e            state;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [FW-1:0]     frame_sr;
  logic              load_p1;
  logic              sync_bad;

  always_comb begin
    sync_bad = ((state == ST_SYNC_LO) && (line != SYNC_LO_BIT)) ||
               ((state == ST_SYNC_HI) && (line != SYNC_HI_BIT));
  end

  // Stage p0: LSB-first shift; after FW data samples bit 0 sits at frame_sr[0]
  always_ff @(posedge clk) begin
    if (state == ST_DATA) frame_sr <= {line, frame_sr[FW-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_DISARMED;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      run_cnt     <= '0;
      load_p1     <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      load_p1     <= 1'b0;

      // Stage p1: publish the completed shift register one cycle after its last bit
      if (load_p1) begin
        frame       <= frame_sr;
        frame_valid <= 1'b1;
      end

      if (sync_bad) begin
        frame_err <= 1'b1;
        err_cnt   <= sat_inc(err_cnt);
        run_cnt   <= '0;
        busy      <= 1'b0;
        state     <= ST_DISARMED;
      end else begin
        case (state)
          ST_DISARMED: begin
            if (line) begin
              run_cnt <= '0;
            end else if (run_cnt >= RUN_W'(IDLE_MIN - 1)) begin
              run_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
          end
          ST_IDLE: begin
            // The first byte's sync '0' is indistinguishable from idle, so only its '1' is seen
            if (line == SYNC_HI_BIT) begin
              bit_cnt  <= '0;
              byte_cnt <= '0;
              busy     <= 1'b1;
              state    <= ST_DATA;
            end
          end
          ST_DATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt == BYTE_W'(NBYTES - 1)) begin
                load_p1 <= 1'b1;
                run_cnt <= '0;
                busy    <= 1'b0;
                state   <= ST_DISARMED;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
                state    <= ST_SYNC_LO;
              end
            end
          end
          ST_SYNC_LO: state <= ST_SYNC_HI;
          ST_SYNC_HI: begin
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_DISARMED;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_deserializer_from_scope.sv
// Directed bench for deserializer_from_scope: table of frames plus hand-written corner sequences.
module tb_deserializer_from_scope;

`ifdef DESER_INSYNC_EN
  localparam int LAT = 41;
`else
  localparam int LAT = 39;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_in = 1'b0;
  logic [31:0] frame;
  logic        frame_valid;
  logic        frame_err;
  logic        busy;
  logic [7:0]  err_cnt;

  always #2 clk = ~clk;

  deserializer_from_scope #(.NBYTES(4), .IDLE_MIN(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .err_cnt     (err_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_valid = 0;
  int          n_err = 0;
  int          n_both = 0;
  int          valid_cyc = -1;
  logic [31:0] vq[$];

  always @(negedge clk) begin
    if (frame_valid) begin
      n_valid++;
      valid_cyc = cyc;
      vq.push_back(frame);
    end
    if (frame_err) n_err++;
    if (frame_valid && frame_err) n_both++;
  end

  int n_tests = 0;
  int n_fail = 0;
  int t0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    data_in = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  // Wire bit w: w%10==0 sync '0', w%10==1 sync '1', else data bit (w%10-2) of byte w/10
  task automatic send_frame(input logic [31:0] v, input int flip_at, input int stop_at);
    logic b;
    int   k;
    int   p;
    for (int w = 0; w < stop_at; w++) begin
      k = w / 10;
      p = w % 10;
      if (p == 0)      b = 1'b0;
      else if (p == 1) b = 1'b1;
      else             b = v[8*k + p - 2];
      if (w == flip_at) b = ~b;
      send_bit(b);
      if (w == 1) t0 = cyc + 1;
    end
  endtask

  typedef struct {
    int          gap;
    logic [31:0] val;
    int          flip_at;
    int          stop_at;
    int          exp_v;
    int          exp_e;
    logic [31:0] exp_frame;
    logic [7:0]  exp_ec;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bv;
    int be;

    vecs[0] = '{5, 32'hA5C3_0F81, -1, 40, 1, 0, 32'hA5C3_0F81, 8'd0};
    vecs[1] = '{3, 32'h00FF_00FF, -1, 40, 1, 0, 32'h00FF_00FF, 8'd0};
    vecs[2] = '{2, 32'h8000_0000, -1, 40, 1, 0, 32'h8000_0000, 8'd0};
    vecs[3] = '{3, 32'h5A5A_5A5A, 21, 22, 0, 1, 32'h8000_0000, 8'd1};
    vecs[4] = '{2, 32'h1234_5678, 30, 31, 0, 1, 32'h8000_0000, 8'd2};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_frame", frame, 32'h0);
    chk("reset_valid", 32'(frame_valid), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_errcnt", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      bv = n_valid;
      be = n_err;
      idle(vecs[i].gap);
      send_frame(vecs[i].val, vecs[i].flip_at, vecs[i].stop_at);
      idle(6);
      #1;
      chk($sformatf("vec%0d_valid_pulses", i), 32'(n_valid - bv), 32'(vecs[i].exp_v));
      chk($sformatf("vec%0d_err_pulses", i), 32'(n_err - be), 32'(vecs[i].exp_e));
      chk($sformatf("vec%0d_frame", i), frame, vecs[i].exp_frame);
      chk($sformatf("vec%0d_errcnt", i), 32'(err_cnt), 32'(vecs[i].exp_ec));
      if (vecs[i].exp_v != 0)
        chk($sformatf("vec%0d_latency", i), 32'(valid_cyc - t0), 32'(LAT));
    end

    // Back-to-back frames: the second frame's sync '0' is the only gap bit
    bv = n_valid;
    send_frame(32'h0000_0001, -1, 40);
    send_frame(32'hFFFF_FFFF, -1, 40);
    idle(6);
    #1;
    chk("b2b_valid_pulses", 32'(n_valid - bv), 32'd2);
    if (vq.size() >= 2) begin
      chk("b2b_first", vq[vq.size()-2], 32'h0000_0001);
      chk("b2b_second", vq[vq.size()-1], 32'hFFFF_FFFF);
    end else begin
      chk("b2b_queue_depth", 32'(vq.size()), 32'd2);
    end
    chk("b2b_latency", 32'(valid_cyc - t0), 32'(LAT));

    // Error, then line stuck high, then recovery
    bv = n_valid;
    be = n_err;
    send_frame(32'hCAFE_F00D, 21, 22);
    for (int i = 0; i < 100; i++) send_bit(1'b1);
    #1;
    chk("stuck_err_pulses", 32'(n_err - be), 32'd1);
    chk("stuck_valid_pulses", 32'(n_valid - bv), 32'd0);
    chk("stuck_busy", 32'(busy), 32'd0);
    chk("stuck_errcnt", 32'(err_cnt), 32'd3);
    send_bit(1'b0);
    send_frame(32'h1234_5678, -1, 40);
    idle(6);
    #1;
    chk("recover_valid_pulses", 32'(n_valid - bv), 32'd1);
    chk("recover_err_pulses", 32'(n_err - be), 32'd1);
    chk("recover_frame", frame, 32'h1234_5678);
    chk("recover_latency", 32'(valid_cyc - t0), 32'(LAT));

    // Asynchronous reset in the middle of a frame
    bv = n_valid;
    idle(2);
    send_frame(32'h5555_AAAA, -1, 20);
    send_bit(1'b0);
    send_bit(1'b0);
    #1;
    chk("midframe_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_frame", frame, 32'h0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_errcnt", 32'(err_cnt), 32'd0);
    chk("async_rst_valid", 32'(frame_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    send_frame(32'hDEAD_BEEF, -1, 40);
    idle(6);
    #1;
    chk("post_rst_valid_pulses", 32'(n_valid - bv), 32'd1);
    chk("post_rst_frame", frame, 32'hDEAD_BEEF);

    // Error counter saturation
    be = n_err;
    for (int i = 0; i < 200; i++) send_frame(32'h0, 10, 11);
    idle(6);
    #1;
    chk("errcnt_200", 32'(err_cnt), 32'd200);
    for (int i = 0; i < 55; i++) send_frame(32'h0, 10, 11);
    idle(6);
    #1;
    chk("errcnt_255", 32'(err_cnt), 32'd255);
    for (int i = 0; i < 10; i++) send_frame(32'h0, 10, 11);
    idle(6);
    #1;
    chk("errcnt_saturated", 32'(err_cnt), 32'd255);
    chk("sat_err_pulses", 32'(n_err - be), 32'd265);
    chk("sat_frame_kept", frame, 32'hDEAD_BEEF);
    chk("valid_err_overlap", 32'(n_both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
